// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg
//   Opcode constants, ALU codes, FSM state encodings, the instruction-class
//   enum and the packed control-strobe record shared by the sequencer files.
package control_sequencer_pkg;

   localparam int OPW  = 5;
   localparam int ALUW = 5;
   localparam int ST_W = 5;

   localparam logic [OPW-1:0] OP_LD   = 5'b00000;
   localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
   localparam logic [OPW-1:0] OP_ST   = 5'b00010;
   localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPW-1:0] OP_AND  = 5'b00101;
   localparam logic [OPW-1:0] OP_OR   = 5'b00110;
   localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
   localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
   localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
   localparam logic [OPW-1:0] OP_BR   = 5'b10010;
   localparam logic [OPW-1:0] OP_JR   = 5'b10011;
   localparam logic [OPW-1:0] OP_JAL  = 5'b10100;
   localparam logic [OPW-1:0] OP_IN   = 5'b10101;
   localparam logic [OPW-1:0] OP_OUT  = 5'b10110;
   localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
   localparam logic [OPW-1:0] OP_HALT = 5'b11011;

   localparam logic [ALUW-1:0] ALU_ADD = 5'b00011;
   localparam logic [ALUW-1:0] ALU_AND = 5'b00101;
   localparam logic [ALUW-1:0] ALU_OR  = 5'b00110;

   localparam logic [ST_W-1:0] S_RESET = 5'd0;
   localparam logic [ST_W-1:0] S_T0    = 5'd1;
   localparam logic [ST_W-1:0] S_T1    = 5'd2;
   localparam logic [ST_W-1:0] S_T2    = 5'd3;
   localparam logic [ST_W-1:0] S_T3    = 5'd4;
   localparam logic [ST_W-1:0] S_T4    = 5'd5;
   localparam logic [ST_W-1:0] S_T5    = 5'd6;
   localparam logic [ST_W-1:0] S_T6    = 5'd7;
   localparam logic [ST_W-1:0] S_T7    = 5'd8;
   localparam logic [ST_W-1:0] S_HALT  = 5'd9;

   typedef enum logic [3:0] {
      C_LD, C_LDI, C_ST, C_ALU_R, C_ALU_I, C_BR, C_JR,
      C_JAL, C_IN, C_OUT, C_NOP, C_HALT, C_ILL
   } instr_class_e;

   typedef struct packed {
      logic            pc_out;
      logic            inc_pc;
      logic            pc_in;
      logic            mar_in;
      logic            mdr_in;
      logic            mdr_out;
      logic            ir_in;
      logic            y_in;
      logic            gra;
      logic            grb;
      logic            grc;
      logic            r_in;
      logic            r_out;
      logic            ba_out;
      logic            c_out;
      logic            r15_in;
      logic            zlo_in;
      logic            zmux_en;
      logic            zmux_out;
      logic            read;
      logic            write;
      logic            ram_en;
      logic            con_in;
      logic            out_port_en;
      logic            port_in_out;
      logic            illegal_op;
      logic [ALUW-1:0] alu_ctl;
   } ctrl_t;

endpackage

// File: rtl/control_sequencer_decode.sv
// control_sequencer_decode
//   Combinational opcode classifier.
//   opcode      in  IR[31:27]
//   instr_class out instruction class driving the sequencer's execute steps
//   imm_alu_op  out ALU code for the immediate forms (0 otherwise)
module control_sequencer_decode
   import control_sequencer_pkg::*;
(
   input  logic [OPW-1:0]  opcode,
   output instr_class_e    instr_class,
   output logic [ALUW-1:0] imm_alu_op
);

   always_comb begin
      instr_class = C_ILL;
      imm_alu_op  = '0;
      case (opcode)
         OP_LD:                       instr_class = C_LD;
         OP_LDI:                      instr_class = C_LDI;
         OP_ST:                       instr_class = C_ST;
         OP_ADD, OP_SUB, OP_AND, OP_OR: instr_class = C_ALU_R;
         OP_ADDI: begin instr_class = C_ALU_I; imm_alu_op = ALU_ADD; end
         OP_ANDI: begin instr_class = C_ALU_I; imm_alu_op = ALU_AND; end
         OP_ORI:  begin instr_class = C_ALU_I; imm_alu_op = ALU_OR;  end
         OP_BR:                       instr_class = C_BR;
         OP_JR:                       instr_class = C_JR;
         OP_JAL:                      instr_class = C_JAL;
         OP_IN:                       instr_class = C_IN;
         OP_OUT:                      instr_class = C_OUT;
         OP_NOP:                      instr_class = C_NOP;
         OP_HALT:                     instr_class = C_HALT;
         default:                     instr_class = C_ILL;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired Moore sequencer for the DataPath: fetch, decode, per-opcode execute.
//   clock, clear (async, active-low)   clocking / reset
//   IR, CON, stop                      instruction, branch flag, halt request
//   PCout..PortInout                   datapath / register / memory / I/O strobes
//   aluControl, run, illegal_op        ALU op, executing flag, undefined-opcode pulse
//   present_state                      current state (debug)
//
// state   | meaning
// RESET   | held while clear=0, all outputs low
// T0..T2  | fetch: PC->MAR, memory read, MDR->IR
// T3..T7  | execute steps, sequence chosen by instruction class
// HALT    | stopped, absorbing until clear=0
module control_sequencer
   import control_sequencer_pkg::*;
(
   input  logic            clock,
   input  logic            clear,
   input  logic [31:0]     IR,
   input  logic            CON,
   input  logic            stop,
   output logic            PCout,
   output logic            IncPC,
   output logic            PCin,
   output logic            MARin,
   output logic            MDRin,
   output logic            MDRout,
   output logic            IRin,
   output logic            Yin,
   output logic            Gra,
   output logic            Grb,
   output logic            Grc,
   output logic            Rin,
   output logic            Rout,
   output logic            BAout,
   output logic            Cout,
   output logic            R15in,
   output logic            ZLOin,
   output logic            ZMuxEnable,
   output logic            ZMuxOut,
   output logic            ZSelect,
   output logic            read,
   output logic            write,
   output logic            RAMenable,
   output logic            conin,
   output logic            OutPortenable,
   output logic            PortInout,
   output logic [ALUW-1:0] aluControl,
   output logic            run,
   output logic            illegal_op,
   output logic [ST_W-1:0] present_state
);

   logic [ST_W-1:0] state_q, state_d;
   logic [OPW-1:0]  opcode;
   instr_class_e    cls;
   logic [ALUW-1:0] imm_op;
   logic            last_step;
   ctrl_t           ctl;
   logic            unused_ir;

   assign opcode    = IR[31:27];
   assign unused_ir = ^IR[26:0];

   control_sequencer_decode u_decode (
      .opcode      (opcode),
      .instr_class (cls),
      .imm_alu_op  (imm_op)
   );

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) state_q <= S_RESET;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      last_step = 1'b0;
      case (state_q)
         S_RESET: state_d = S_T0;
         S_T0:    state_d = S_T1;
         S_T1:    state_d = S_T2;
         S_T2: begin
            if (cls == C_HALT)     state_d = S_HALT;
            else if (cls == C_NOP) last_step = 1'b1;
            else                   state_d = S_T3;
         end
         S_T3: begin
            if (cls inside {C_JR, C_IN, C_OUT, C_ILL}) last_step = 1'b1;
            else                                       state_d = S_T4;
         end
         S_T4: begin
            if (cls == C_JAL) last_step = 1'b1;
            else              state_d = S_T5;
         end
         S_T5: begin
            if (cls inside {C_LDI, C_ALU_R, C_ALU_I}) last_step = 1'b1;
            else                                      state_d = S_T6;
         end
         S_T6: begin
            if (cls == C_BR) last_step = 1'b1;
            else             state_d = S_T7;
         end
         S_T7:    last_step = 1'b1;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_RESET;
      endcase
      // stop only takes effect at an instruction boundary
      if (last_step) state_d = stop ? S_HALT : S_T0;
   end

   always_comb begin
      ctl = '0;
      case (state_q)
         S_T0: begin ctl.pc_out = 1'b1; ctl.mar_in = 1'b1; ctl.inc_pc = 1'b1; end
         S_T1: begin ctl.read = 1'b1; ctl.ram_en = 1'b1; ctl.mdr_in = 1'b1; end
         S_T2: begin ctl.mdr_out = 1'b1; ctl.ir_in = 1'b1; end
         S_T3: begin
            case (cls)
               C_LD, C_LDI, C_ST: begin ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_in = 1'b1; end
               C_ALU_R, C_ALU_I:  begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1; end
               C_BR:  begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.con_in = 1'b1; end
               C_JR:  begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.pc_in = 1'b1; end
               C_JAL: begin ctl.pc_out = 1'b1; ctl.r15_in = 1'b1; end
               C_IN:  begin ctl.port_in_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
               C_OUT: begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.out_port_en = 1'b1; end
               C_ILL: ctl.illegal_op = 1'b1;
               default: ;
            endcase
         end
         S_T4: begin
            case (cls)
               C_LD, C_LDI, C_ST: begin ctl.c_out = 1'b1; ctl.alu_ctl = ALU_ADD; ctl.zlo_in = 1'b1; end
               C_ALU_R: begin ctl.grc = 1'b1; ctl.r_out = 1'b1; ctl.alu_ctl = opcode; ctl.zlo_in = 1'b1; end
               C_ALU_I: begin ctl.c_out = 1'b1; ctl.alu_ctl = imm_op; ctl.zlo_in = 1'b1; end
               C_BR:    begin ctl.pc_out = 1'b1; ctl.y_in = 1'b1; end
               C_JAL:   begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.pc_in = 1'b1; end
               default: ;
            endcase
         end
         S_T5: begin
            case (cls)
               C_LD, C_ST: begin ctl.zmux_en = 1'b1; ctl.zmux_out = 1'b1; ctl.mar_in = 1'b1; end
               C_LDI, C_ALU_R, C_ALU_I: begin
                  ctl.zmux_en = 1'b1; ctl.zmux_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
               end
               C_BR: begin ctl.c_out = 1'b1; ctl.alu_ctl = ALU_ADD; ctl.zlo_in = 1'b1; end
               default: ;
            endcase
         end
         S_T6: begin
            case (cls)
               C_LD: begin ctl.read = 1'b1; ctl.ram_en = 1'b1; ctl.mdr_in = 1'b1; end
               C_ST: begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.mdr_in = 1'b1; end
               C_BR: if (CON) begin ctl.zmux_en = 1'b1; ctl.zmux_out = 1'b1; ctl.pc_in = 1'b1; end
               default: ;
            endcase
         end
         S_T7: begin
            case (cls)
               C_LD: begin ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
               C_ST: begin ctl.write = 1'b1; ctl.ram_en = 1'b1; end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign PCout         = ctl.pc_out;
   assign IncPC         = ctl.inc_pc;
   assign PCin          = ctl.pc_in;
   assign MARin         = ctl.mar_in;
   assign MDRin         = ctl.mdr_in;
   assign MDRout        = ctl.mdr_out;
   assign IRin          = ctl.ir_in;
   assign Yin           = ctl.y_in;
   assign Gra           = ctl.gra;
   assign Grb           = ctl.grb;
   assign Grc           = ctl.grc;
   assign Rin           = ctl.r_in;
   assign Rout          = ctl.r_out;
   assign BAout         = ctl.ba_out;
   assign Cout          = ctl.c_out;
   assign R15in         = ctl.r15_in;
   assign ZLOin         = ctl.zlo_in;
   assign ZMuxEnable    = ctl.zmux_en;
   assign ZMuxOut       = ctl.zmux_out;
   assign ZSelect       = 1'b0;   // Z path always selects ZLO
   assign read          = ctl.read;
   assign write         = ctl.write;
   assign RAMenable     = ctl.ram_en;
   assign conin         = ctl.con_in;
   assign OutPortenable = ctl.out_port_en;
   assign PortInout     = ctl.port_in_out;
   assign aluControl    = ctl.alu_ctl;
   assign illegal_op    = ctl.illegal_op;
   assign run           = (state_q != S_RESET) && (state_q != S_HALT);
   assign present_state = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;
   import control_sequencer_pkg::*;

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] IR    = '0;
   logic        CON   = 1'b0;
   logic        stop  = 1'b0;
   logic PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, Yin;
   logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, R15in;
   logic ZLOin, ZMuxEnable, ZMuxOut, ZSelect;
   logic read, write, RAMenable, conin, OutPortenable, PortInout;
   logic [4:0] aluControl;
   logic       run, illegal_op;
   logic [4:0] present_state;

   always #5 clock = ~clock;

   control_sequencer dut (
      .clock(clock), .clear(clear), .IR(IR), .CON(CON), .stop(stop),
      .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
      .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
      .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout), .R15in(R15in),
      .ZLOin(ZLOin), .ZMuxEnable(ZMuxEnable), .ZMuxOut(ZMuxOut), .ZSelect(ZSelect),
      .read(read), .write(write), .RAMenable(RAMenable), .conin(conin),
      .OutPortenable(OutPortenable), .PortInout(PortInout), .aluControl(aluControl),
      .run(run), .illegal_op(illegal_op), .present_state(present_state)
   );

   localparam logic [25:0] PCO  = 26'd1 << 0;
   localparam logic [25:0] INC  = 26'd1 << 1;
   localparam logic [25:0] PCI  = 26'd1 << 2;
   localparam logic [25:0] MARI = 26'd1 << 3;
   localparam logic [25:0] MDRI = 26'd1 << 4;
   localparam logic [25:0] MDRO = 26'd1 << 5;
   localparam logic [25:0] IRI  = 26'd1 << 6;
   localparam logic [25:0] YI   = 26'd1 << 7;
   localparam logic [25:0] GRA  = 26'd1 << 8;
   localparam logic [25:0] GRB  = 26'd1 << 9;
   localparam logic [25:0] GRC  = 26'd1 << 10;
   localparam logic [25:0] RIN  = 26'd1 << 11;
   localparam logic [25:0] ROUT = 26'd1 << 12;
   localparam logic [25:0] BAO  = 26'd1 << 13;
   localparam logic [25:0] CO   = 26'd1 << 14;
   localparam logic [25:0] R15  = 26'd1 << 15;
   localparam logic [25:0] ZLO  = 26'd1 << 16;
   localparam logic [25:0] ZME  = 26'd1 << 17;
   localparam logic [25:0] ZMO  = 26'd1 << 18;
   localparam logic [25:0] RD   = 26'd1 << 20;
   localparam logic [25:0] WR   = 26'd1 << 21;
   localparam logic [25:0] RAM  = 26'd1 << 22;
   localparam logic [25:0] CONI = 26'd1 << 23;
   localparam logic [25:0] OPE  = 26'd1 << 24;
   localparam logic [25:0] PIO  = 26'd1 << 25;

   typedef struct {
      logic [39:0] expv;
      logic [31:0] ir;
      logic        con;
      logic        stp;
      string       tag;
   } item_t;

   item_t       sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] cur_ir;
   string       cur_name;

   function automatic logic [39:0] observed();
      return {2'b00, present_state, illegal_op, run, aluControl,
              PortInout, OutPortenable, conin, RAMenable, write, read, ZSelect,
              ZMuxOut, ZMuxEnable, ZLOin, R15in, Cout, BAout, Rout, Rin, Grc, Grb,
              Gra, Yin, IRin, MDRout, MDRin, MARin, PCin, IncPC, PCout};
   endfunction

   function automatic logic [39:0] ev(input logic [4:0] s, input logic [25:0] m,
                                      input logic [4:0] alu, input logic ill);
      logic r;
      r = (s != S_RESET) && (s != S_HALT);
      return {2'b00, s, ill, r, alu, m};
   endfunction

   task automatic check(input string tag, input logic [39:0] got, input logic [39:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, expv);
      end
   endtask

   task automatic push(input logic [4:0] s, input logic [25:0] m, input logic [4:0] alu,
                       input logic ill, input logic c, input logic sp);
      item_t it;
      it.expv = ev(s, m, alu, ill);
      it.ir   = cur_ir;
      it.con  = c;
      it.stp  = sp;
      it.tag  = $sformatf("%s_st%0d", cur_name, s);
      sb.push_back(it);
   endtask

   task automatic start(input string name, input logic [4:0] op, input logic sp_t2);
      cur_name = name;
      cur_ir   = {op, 27'h0800055};
      push(S_T0, PCO | MARI | INC, 5'd0, 1'b0, 1'b0, 1'b0);
      push(S_T1, RD | RAM | MDRI,  5'd0, 1'b0, 1'b0, 1'b0);
      push(S_T2, MDRO | IRI,       5'd0, 1'b0, 1'b0, sp_t2);
   endtask

   task automatic ld_addr();
      push(S_T3, GRB | BAO | YI, 5'd0,     1'b0, 1'b0, 1'b0);
      push(S_T4, CO | ZLO,       5'b00011, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic alu_r(input string name, input logic [4:0] op, input logic sp);
      start(name, op, 1'b0);
      push(S_T3, GRB | ROUT | YI,  5'd0, 1'b0, 1'b0, 1'b0);
      push(S_T4, GRC | ROUT | ZLO, op,   1'b0, 1'b0, sp);
      push(S_T5, ZME | ZMO | GRA | RIN, 5'd0, 1'b0, 1'b0, sp);
   endtask

   task automatic br(input string name, input logic c6);
      start(name, 5'b10010, 1'b0);
      push(S_T3, GRA | ROUT | CONI, 5'd0,     1'b0, ~c6, 1'b0);
      push(S_T4, PCO | YI,          5'd0,     1'b0, ~c6, 1'b0);
      push(S_T5, CO | ZLO,          5'b00011, 1'b0, ~c6, 1'b0);
      push(S_T6, c6 ? (ZME | ZMO | PCI) : 26'd0, 5'd0, 1'b0, c6, 1'b0);
   endtask

   task automatic drain();
      item_t it;
      while (sb.size() > 0) begin
         @(posedge clock);
         #1;
         it   = sb.pop_front();
         IR   = it.ir;
         CON  = it.con;
         stop = it.stp;
         #1;
         check(it.tag, observed(), it.expv);
      end
   endtask

   task automatic clear_pulse();
      #1 clear = 1'b0;
      #1 check("clr_pulse", observed(), 40'd0);
      #1 clear = 1'b1;
   endtask

   initial begin
      #3 check("reset", observed(), 40'd0);
      #9 clear = 1'b1;

      start("ld", 5'b00000, 1'b0);
      ld_addr();
      push(S_T5, ZME | ZMO | MARI,  5'd0, 1'b0, 1'b0, 1'b0);
      push(S_T6, RD | RAM | MDRI,   5'd0, 1'b0, 1'b0, 1'b0);
      push(S_T7, MDRO | GRA | RIN,  5'd0, 1'b0, 1'b0, 1'b0);

      start("st", 5'b00010, 1'b0);
      ld_addr();
      push(S_T5, ZME | ZMO | MARI,  5'd0, 1'b0, 1'b0, 1'b0);
      push(S_T6, GRA | ROUT | MDRI, 5'd0, 1'b0, 1'b0, 1'b0);
      push(S_T7, WR | RAM,          5'd0, 1'b0, 1'b0, 1'b0);

      alu_r("add", 5'b00011, 1'b0);
      alu_r("or",  5'b00110, 1'b0);

      start("andi", 5'b01101, 1'b0);
      push(S_T3, GRB | ROUT | YI, 5'd0, 1'b0, 1'b0, 1'b0);
      push(S_T4, CO | ZLO, 5'b00101, 1'b0, 1'b0, 1'b0);
      push(S_T5, ZME | ZMO | GRA | RIN, 5'd0, 1'b0, 1'b0, 1'b0);

      br("br_con1", 1'b1);
      br("br_con0", 1'b0);

      start("jal", 5'b10100, 1'b0);
      push(S_T3, PCO | R15,         5'd0, 1'b0, 1'b0, 1'b0);
      push(S_T4, GRA | ROUT | PCI,  5'd0, 1'b0, 1'b0, 1'b0);

      start("in", 5'b10101, 1'b0);
      push(S_T3, PIO | GRA | RIN,   5'd0, 1'b0, 1'b0, 1'b0);
      start("out", 5'b10110, 1'b0);
      push(S_T3, GRA | ROUT | OPE,  5'd0, 1'b0, 1'b0, 1'b0);

      start("ill", 5'b11111, 1'b0);
      push(S_T3, 26'd0, 5'd0, 1'b1, 1'b0, 1'b0);

      start("nop", 5'b11010, 1'b0);

      start("ldi", 5'b00001, 1'b0);
      ld_addr();
      push(S_T5, ZME | ZMO | GRA | RIN, 5'd0, 1'b0, 1'b0, 1'b0);

      start("ld_abort", 5'b00000, 1'b0);
      ld_addr();
      push(S_T5, ZME | ZMO | MARI, 5'd0, 1'b0, 1'b0, 1'b0);
      drain();

      // asynchronous clear in the middle of T5
      #1 clear = 1'b0;
      #1 check("clr_async", observed(), 40'd0);
      @(posedge clock);
      #1 check("clr_hold", observed(), 40'd0);
      #1 clear = 1'b1;

      alu_r("sub_stop", 5'b00100, 1'b1);
      push(S_HALT, 26'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      push(S_HALT, 26'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      drain();
      clear_pulse();

      start("halt", 5'b11011, 1'b0);
      push(S_HALT, 26'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      push(S_HALT, 26'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      drain();
      clear_pulse();

      start("nop_stop", 5'b11010, 1'b1);
      push(S_HALT, 26'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
